// File: rtl/seg7_pkg.sv
// Shared constants for the 8-digit common-anode seven-segment scan driver.
package seg7_pkg;

  // Every segment off, including the decimal point (active-low).
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  // No digit enabled (active-low).
  localparam logic [7:0] AN_OFF    = 8'hFF;
  // Segments a..g all off.
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  // Hex digit -> {g,f,e,d,c,b,a}, active-low. Index 15 is listed first.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // Blink phase: lit half-period, then blanked half-period.
  typedef enum logic {
    PH_SHOW  = 1'b0,
    PH_BLANK = 1'b1
  } blink_phase_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low a..g segment pattern.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Straight table lookup; the decimal point is handled by the caller.
  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit seven-segment driver with per-frame input snapshot,
// hex decode, per-digit blink and optional leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EN,
  input  logic [31:0] Disp_num,
  input  logic [7:0]  point_in,
  input  logic [7:0]  blink_in,
  input  logic        lzs,
  output logic [7:0]  AN,
  output logic [7:0]  SEGMENT,
  output logic        frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] prescaler;
  logic [2:0]    digit;
  logic          tc;
  logic          boundary;

  logic          first;
  logic [31:0]   snap_num;
  logic [7:0]    snap_pt;
  logic [7:0]    snap_bl;
  logic [31:0]   eff_num;
  logic [7:0]    eff_pt;
  logic [7:0]    eff_bl;

  blink_phase_t  phase;
  blink_phase_t  phase_next;
  logic [BW-1:0] blink_cnt;
  logic [BW-1:0] blink_cnt_next;

  logic [3:0]    nibble;
  logic [6:0]    hex_seg;
  logic [31:0]   upper;
  logic          lz_blank;
  logic          bl_blank;
  logic [7:0]    seg_next;

  assign tc       = (prescaler == PW'(SCAN_DIV - 1));
  assign boundary = tc && (digit == 3'd7);

  // On the very first edge out of reset the snapshot registers still hold
  // zero, so the live inputs are used directly; this makes the first lit
  // digit already show the captured word.
  assign eff_num = first ? Disp_num : snap_num;
  assign eff_pt  = first ? point_in : snap_pt;
  assign eff_bl  = first ? blink_in : snap_bl;

  // Prescaler and digit counter: one digit per SCAN_DIV cycles, 0..7 wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler <= '0;
      digit     <= 3'd0;
    end else if (tc) begin
      prescaler <= '0;
      digit     <= digit + 3'd1;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // Snapshot: forced on the first edge after reset, then only at frame
  // boundaries with EN high, so a frame never mixes two words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first    <= 1'b1;
      snap_num <= '0;
      snap_pt  <= '0;
      snap_bl  <= '0;
    end else begin
      first <= 1'b0;
      if (first || (boundary && EN)) begin
        snap_num <= Disp_num;
        snap_pt  <= point_in;
        snap_bl  <= blink_in;
      end
    end
  end

  // Blink state register: phase bit plus frame counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase     <= PH_SHOW;
      blink_cnt <= '0;
    end else begin
      phase     <= phase_next;
      blink_cnt <= blink_cnt_next;
    end
  end

  // Blink next state: count frames, flip phase when the count wraps.
  always_comb begin
    phase_next     = phase;
    blink_cnt_next = blink_cnt;
    if (boundary) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_next = '0;
        phase_next     = (phase == PH_SHOW) ? PH_BLANK : PH_SHOW;
      end else begin
        blink_cnt_next = blink_cnt + BW'(1);
      end
    end
  end

  assign nibble = eff_num[{digit, 2'b00} +: 4];

  hex_to_seg7 u_hex (
    .nibble (nibble),
    .seg    (hex_seg)
  );

  // A digit is a leading zero when it and every more significant nibble is 0.
  assign upper    = eff_num >> {digit, 2'b00};
  assign lz_blank = lzs && (digit != 3'd0) && (upper == 32'd0);
  assign bl_blank = (phase == PH_BLANK) && eff_bl[digit];

  // Segment selection: blink blank wins over zero blanking over decode.
  always_comb begin
    seg_next = {~eff_pt[digit], hex_seg};
    if (bl_blank) begin
      seg_next = SEG_BLANK;
    end else if (lz_blank) begin
      seg_next = {~eff_pt[digit], SEG_OFF};
    end
  end

  // Registered outputs, one cycle behind the digit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      AN         <= AN_OFF;
      SEGMENT    <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      AN         <= ~(8'b1 << digit);
      SEGMENT    <= seg_next;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized scoreboard bench for seg7_scan_driver (SCAN_DIV=4, BLINK_FRAMES=2).
module tb_seg7_scan_driver;

  localparam int SD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = 8 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        EN = 1'b0;
  logic [31:0] Disp_num = '0;
  logic [7:0]  point_in = '0;
  logic [7:0]  blink_in = '0;
  logic        lzs = 1'b0;
  logic [7:0]  AN;
  logic [7:0]  SEGMENT;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
    logic       fd;
    int         n;
  } exp_t;

  exp_t sb[$];

  // Display font straight from the character table (dp bit included, off).
  logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg7_scan_driver #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .rst        (rst),
    .EN         (EN),
    .Disp_num   (Disp_num),
    .point_in   (point_in),
    .blink_in   (blink_in),
    .lzs        (lzs),
    .AN         (AN),
    .SEGMENT    (SEGMENT),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: everything derives from the number of clock edges since
  // reset release. Edge n shows time slot t=n-1: digit (t/SD)%8 of frame t/FRAME.
  int          n = 0;
  logic [31:0] m_num = '0;
  logic [7:0]  m_pt = '0;
  logic [7:0]  m_bl = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb.delete();
      n = 0;
    end else begin
      int   t, dig, frame, ph;
      exp_t e;
      n = n + 1;
      if (n == 1) begin
        m_num = Disp_num; m_pt = point_in; m_bl = blink_in;
      end
      t     = n - 1;
      dig   = (t / SD) % 8;
      frame = t / FRAME;
      ph    = (frame / BF) % 2;
      e.n   = n;
      e.an  = 8'hFF & ~(8'h01 << dig);
      e.fd  = (n % FRAME == 0);
      if (ph == 1 && m_bl[dig])
        e.seg = 8'hFF;
      else if (lzs && dig > 0 && (m_num >> (4 * dig)) == 32'd0)
        e.seg = {~m_pt[dig], 7'h7F};
      else
        e.seg = {~m_pt[dig], font[(m_num >> (4 * dig)) & 32'hF][6:0]};
      sb.push_back(e);
      if (n % FRAME == 0 && EN) begin
        m_num = Disp_num; m_pt = point_in; m_bl = blink_in;
      end
    end
  end

  // Monitor: reset values while rst is low (checked 1 ns after an async
  // assertion too), otherwise pop the scoreboard each cycle and compare.
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      #1;
      checks = checks + 3;
      if (AN !== 8'hFF) begin
        failures++; $display("FAIL reset_an got=%h exp=ff t=%0t", AN, $time);
      end
      if (SEGMENT !== 8'hFF) begin
        failures++; $display("FAIL reset_seg got=%h exp=ff t=%0t", SEGMENT, $time);
      end
      if (frame_done !== 1'b0) begin
        failures++; $display("FAIL reset_fd got=%b exp=0 t=%0t", frame_done, $time);
      end
    end else if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks = checks + 3;
      if (AN !== e.an) begin
        failures++; $display("FAIL an n=%0d got=%h exp=%h", e.n, AN, e.an);
      end
      if (SEGMENT !== e.seg) begin
        failures++; $display("FAIL segment n=%0d got=%h exp=%h", e.n, SEGMENT, e.seg);
      end
      if (frame_done !== e.fd) begin
        failures++; $display("FAIL frame_done n=%0d got=%b exp=%b", e.n, frame_done, e.fd);
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    tick(3);

    // Basic scan of 0x000000FF.
    EN = 1'b1; Disp_num = 32'h0000_00FF; point_in = '0; blink_in = '0; lzs = 1'b0;
    rst = 1'b1;
    tick(64);

    // Mid-frame change with EN=1, then frozen snapshot with EN=0.
    tick(12);
    Disp_num = $urandom;
    tick(52);
    EN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      Disp_num = $urandom;
      point_in = 8'($urandom);
      tick(16);
    end

    // Decimal point on digit 0, blink on digit 7.
    EN = 1'b1; point_in = 8'h01; blink_in = 8'h80; Disp_num = 32'h1234_5678;
    tick(8 * FRAME);

    // Leading-zero blanking.
    point_in = '0; blink_in = '0; lzs = 1'b1; Disp_num = 32'h0000_0000;
    tick(2 * FRAME);
    Disp_num = 32'h0001_0000;
    tick(2 * FRAME);

    // Randomized traffic with live lzs and occasional EN drops.
    for (int i = 0; i < 640; i++) begin
      if ($urandom_range(0, 7) == 0) Disp_num = $urandom >> (4 * $urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) point_in = 8'($urandom);
      if ($urandom_range(0, 15) == 0) blink_in = 8'($urandom);
      if ($urandom_range(0, 31) == 0) EN = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 23) == 0) lzs = ~lzs;
      tick(1);
    end

    // Async reset while digit 5 is lit; restart with EN low.
    rst = 1'b0;
    tick(2);
    EN = 1'b1; Disp_num = $urandom; rst = 1'b1;
    tick(22);
    rst = 1'b0;
    tick(3);
    EN = 1'b0; Disp_num = $urandom; point_in = 8'($urandom); blink_in = 8'($urandom);
    rst = 1'b1;
    tick(3 * FRAME);

    tick(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
